// File: rtl/cache_controller.sv
// cache_controller: blocking write-back cache FSM with memory timeout and saturating hit/miss statistics.
module cache_controller #(
   parameter int ADDR_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cpu_req_valid,
   input  logic                  cpu_req_type,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   output logic                  cpu_ready,
   output logic                  cpu_done,
   output logic                  mem_err,
   output logic                  req_type,
   output logic [ADDR_WIDTH-1:0] addr_q,
   input  logic                  hit,
   input  logic                  dirty_bit,
   input  logic                  done_cache,
   output logic                  read_en_cache,
   output logic                  write_en_cache,
   output logic                  refill,
   output logic                  read_en_mem,
   output logic                  write_en_mem,
   input  logic                  mem_ack,
   output logic [CNT_WIDTH-1:0]  hit_count,
   output logic [CNT_WIDTH-1:0]  miss_count
);
   localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
   typedef enum logic [2:0] {IDLE, COMPARE, RESPOND, EVICT, WRITEBACK, ALLOCATE, REFILL} state_t;
   state_t                  state_q, state_d;
   logic [WW-1:0]           wait_q, wait_d;
   logic [ADDR_WIDTH-1:0]   addr_d;
   logic [CNT_WIDTH-1:0]    hit_q, hit_d, miss_q, miss_d;
   logic                    type_q, type_d, retry_q, retry_d, done_q, done_d, err_q, err_d;
   logic                    expired;
   // The expiring cycle is the last wait cycle; an ack in that same cycle still wins.
   assign expired    = (wait_q == WW'(TIMEOUT_CYCLES - 1)) & ~mem_ack;
   assign cpu_ready  = (state_q == IDLE) & ~rst;
   assign cpu_done   = done_q;
   assign mem_err    = err_q;
   assign req_type   = type_q;
   assign hit_count  = hit_q;
   assign miss_count = miss_q;
   // State, latched request, wait counter and statistics registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         wait_q  <= '0;
         addr_q  <= '0;
         type_q  <= 1'b0;
         retry_q <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         hit_q   <= '0;
         miss_q  <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         addr_q  <= addr_d;
         type_q  <= type_d;
         retry_q <= retry_d;
         done_q  <= done_d;
         err_q   <= err_d;
         hit_q   <= hit_d;
         miss_q  <= miss_d;
      end
   end
   // Next-state and enable decode; a retry after refill is never counted again.
   always_comb begin
      state_d        = state_q;
      addr_d         = addr_q;
      type_d         = type_q;
      retry_d        = retry_q;
      done_d         = 1'b0;
      err_d          = 1'b0;
      hit_d          = hit_q;
      miss_d         = miss_q;
      read_en_cache  = 1'b0;
      write_en_cache = 1'b0;
      refill         = 1'b0;
      read_en_mem    = 1'b0;
      write_en_mem   = 1'b0;
      case (state_q)
         IDLE: if (cpu_req_valid) begin
            addr_d  = cpu_addr;
            type_d  = cpu_req_type;
            state_d = COMPARE;
         end
         COMPARE: begin
            retry_d = 1'b0;
            if (hit) begin
               read_en_cache  = ~type_q;
               write_en_cache = type_q;
               hit_d          = (retry_q || &hit_q) ? hit_q : hit_q + 1'b1;
               state_d        = RESPOND;
            end else begin
               read_en_cache = dirty_bit;
               miss_d        = (retry_q || &miss_q) ? miss_q : miss_q + 1'b1;
               state_d       = dirty_bit ? EVICT : ALLOCATE;
            end
         end
         RESPOND: if (done_cache) begin
            done_d  = 1'b1;
            state_d = IDLE;
         end
         EVICT: state_d = WRITEBACK;
         WRITEBACK: begin
            write_en_mem = 1'b1;
            err_d        = expired;
            state_d      = mem_ack ? ALLOCATE : expired ? IDLE : WRITEBACK;
         end
         ALLOCATE: begin
            read_en_mem = 1'b1;
            err_d       = expired;
            state_d     = mem_ack ? REFILL : expired ? IDLE : ALLOCATE;
         end
         REFILL: begin
            refill         = 1'b1;
            read_en_mem    = 1'b1;
            write_en_cache = 1'b1;
            retry_d        = 1'b1;
            state_d        = COMPARE;
         end
         default: state_d = IDLE;
      endcase
   end
   // The wait counter runs only while a memory wait state persists; any transition clears it.
   always_comb begin
      wait_d = ((state_d == state_q) && (state_q == WRITEBACK || state_q == ALLOCATE)) ? wait_q + 1'b1 : '0;
   end
endmodule

// File: tb/tb_cache_controller.sv
// tb_cache_controller: directed and randomized transactions against a transaction-level expectation model.
module tb_cache_controller;
   localparam int TO = 4;
   localparam logic [7:0] RDY = 8'h80, DONE = 8'h40, ERR = 8'h20, RDC = 8'h10,
                          WRC = 8'h08, RFL = 8'h04, RDM = 8'h02, WRM = 8'h01;
   logic        clk, rst, cpu_req_valid, cpu_req_type, hit, dirty_bit, done_cache, mem_ack;
   logic [31:0] cpu_addr, addr_q;
   logic        cpu_ready, cpu_done, mem_err, req_type;
   logic        read_en_cache, write_en_cache, refill, read_en_mem, write_en_mem;
   logic [1:0]  hit_count, miss_count;
   logic [44:0] obs;
   int          vectors = 0, errors = 0;
   logic [1:0]  m_hits, m_miss;
   logic        m_type;
   logic [31:0] m_addr;

   cache_controller #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(TO), .CNT_WIDTH(2)) dut (
      .clk(clk), .rst(rst), .cpu_req_valid(cpu_req_valid), .cpu_req_type(cpu_req_type),
      .cpu_addr(cpu_addr), .cpu_ready(cpu_ready), .cpu_done(cpu_done), .mem_err(mem_err),
      .req_type(req_type), .addr_q(addr_q), .hit(hit), .dirty_bit(dirty_bit),
      .done_cache(done_cache), .read_en_cache(read_en_cache), .write_en_cache(write_en_cache),
      .refill(refill), .read_en_mem(read_en_mem), .write_en_mem(write_en_mem),
      .mem_ack(mem_ack), .hit_count(hit_count), .miss_count(miss_count));

   assign obs = {cpu_ready, cpu_done, mem_err, read_en_cache, write_en_cache, refill,
                 read_en_mem, write_en_mem, hit_count, miss_count, req_type, addr_q};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [1:0] sat(input logic [1:0] v);
      return (v == 2'b11) ? v : v + 2'd1;
   endfunction

   task automatic noise();
      hit           = 1'($urandom);
      dirty_bit     = 1'($urandom);
      done_cache    = 1'($urandom);
      mem_ack       = 1'($urandom);
      cpu_req_valid = 1'($urandom);
      cpu_req_type  = 1'($urandom);
      cpu_addr      = $urandom;
   endtask

   task automatic step(input logic [7:0] e, input string tag);
      logic [44:0] want;
      @(negedge clk);
      want = {e, m_hits, m_miss, m_type, m_addr};
      vectors++;
      assert (obs === want) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, want);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      m_hits = '0;
      m_miss = '0;
      m_type = 1'b0;
      m_addr = '0;
   endtask

   task automatic do_reset();
      noise();
      rst = 1'b1;
      model_reset();
      step(8'h00, "reset_hold");
      rst = 1'b0;
      cpu_req_valid = 1'b0;
      step(RDY, "reset_release");
   endtask

   // n idle cycles before the ack; n >= TO means the ack never comes.
   task automatic wait_phase(input logic [7:0] e, input int n, input string tag, output logic timed_out);
      timed_out = 1'b1;
      for (int k = 0; k < TO; k++) begin
         noise();
         mem_ack = (k == n);
         step(e, tag);
         if (k == n) begin
            timed_out = 1'b0;
            break;
         end
      end
   endtask

   task automatic txn(input logic t, input logic [31:0] a, input logic h, input logic d,
                      input int w, input int al, input int r);
      logic fail;
      fail = 1'b0;
      noise();
      cpu_req_valid = 1'b1;
      cpu_req_type  = t;
      cpu_addr      = a;
      step(RDY, "accept");
      m_type = t;
      m_addr = a;
      noise();
      hit       = h;
      dirty_bit = d;
      step(h ? (t ? WRC : RDC) : (d ? RDC : 8'h00), "compare");
      if (h) m_hits = sat(m_hits);
      else m_miss = sat(m_miss);
      if (!h) begin
         if (d) begin
            noise();
            step(8'h00, "evict");
            wait_phase(WRM, w, "writeback", fail);
         end
         if (!fail) wait_phase(RDM, al, "allocate", fail);
         if (!fail) begin
            noise();
            step(RFL | RDM | WRC, "refill");
            noise();
            hit = 1'b1;
            step(t ? WRC : RDC, "retry");
         end
      end
      if (!fail) begin
         for (int k = 0; k < r; k++) begin
            noise();
            done_cache = 1'b0;
            step(8'h00, "respond_wait");
         end
         noise();
         done_cache = 1'b1;
         step(8'h00, "respond_done");
      end
      noise();
      cpu_req_valid = 1'b0;
      step(RDY | (fail ? ERR : DONE), fail ? "timeout_err" : "cpu_done");
   endtask

   initial begin
      rst = 1'b1;
      cpu_req_valid = 1'b0; cpu_req_type = 1'b0; cpu_addr = '0;
      hit = 1'b0; dirty_bit = 1'b0; done_cache = 1'b0; mem_ack = 1'b0;
      model_reset();
      step(8'h00, "reset_hold");
      rst = 1'b0;
      step(RDY, "first_ready");
      txn(1'b0, 32'h100, 1'b1, 1'b0, 0, 0, 1);
      txn(1'b1, 32'h2000, 1'b0, 1'b0, 0, 3, 0);
      txn(1'b1, 32'h3040, 1'b0, 1'b1, 2, 1, 1);
      txn(1'b0, 32'h44, 1'b0, 1'b0, 0, 4, 0);
      txn(1'b1, 32'h88, 1'b0, 1'b1, 5, 0, 0);
      txn(1'b0, 32'hCC, 1'b0, 1'b1, 3, 3, 0);
      // Abort a transaction in the middle of a write-back.
      noise();
      cpu_req_valid = 1'b1; cpu_req_type = 1'b1; cpu_addr = 32'hDEAD_BEE0;
      step(RDY, "accept");
      m_type = 1'b1;
      m_addr = 32'hDEAD_BEE0;
      noise();
      hit = 1'b0; dirty_bit = 1'b1;
      step(RDC, "compare");
      m_miss = sat(m_miss);
      noise();
      step(8'h00, "evict");
      noise();
      mem_ack = 1'b0;
      step(WRM, "writeback");
      mem_ack = 1'b0;
      cpu_req_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      model_reset();
      vectors++;
      assert (obs === 45'd0) else begin
         errors++;
         $error("FAIL async_reset_in_wb: observed %h expected %h", obs, 45'd0);
      end
      step(8'h00, "reset_in_wb_hold");
      rst = 1'b0;
      step(RDY, "ready_after_reset");
      for (int i = 0; i < 5; i++) txn(1'b0, 32'h500 + 32'(i * 4), 1'b1, 1'b0, 0, 0, 0);
      vectors++;
      assert (hit_count === 2'd3) else begin
         errors++;
         $error("FAIL hit_saturation: observed %0d expected 3", hit_count);
      end
      for (int i = 0; i < 80; i++) begin
         if (i % 8 == 0) do_reset();
         txn(1'($urandom), $urandom, 1'($urandom), 1'($urandom),
             int'($urandom_range(0, 5)), int'($urandom_range(0, 5)), int'($urandom_range(0, 2)));
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
